stim_response_engine: RTL and testbench

// - Drives the other end of a generated combinational block: produces IN_W-bit stimulus vectors
//   on stim_data and reads back the OUT_W-bit result on resp_data.
// - Stimulus comes from an LFSR. Each response is compacted into a MISR signature.
// - After NUM_VEC vectors, the signature is reported through a valid/ready handshake.
// - Sits beside each generated block in the self-check wrapper, one instance per block.

---
 rtl/stim_response_engine.sv | 175 +++++++++++++++++
 tb/tb_stim_response_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stim_response_engine.sv
// stim_response_engine
// Drives a combinational block under test with LFSR-generated stimulus, folds every
// response into a MISR signature, and reports the signature through a valid/ready
// handshake after NUM_VEC vectors.
// Optional feature macro: STIM_RESP_CMP_EN adds the GOLDEN parameter, a golden-signature
// comparator and the registered 'pass' output. Without it the comparator is absent.
module stim_response_engine #(
  parameter int              IN_W       = 5,
  parameter int              OUT_W      = 10,
  parameter int              NUM_VEC    = 32,
  parameter int              SETTLE_CYC = 1,
  parameter logic [IN_W-1:0] LFSR_SEED  = 5'h01
`ifdef STIM_RESP_CMP_EN
  ,
  parameter logic [OUT_W-1:0] GOLDEN    = 10'h000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] resp_data,
  output logic [IN_W-1:0]  stim_data,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [OUT_W-1:0] signature,
  output logic [9:0]       vec_count
`ifdef STIM_RESP_CMP_EN
  ,
  output logic             pass
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED        = (LFSR_SEED == '0) ? 5'h01 : LFSR_SEED;
  localparam logic [9:0]      NUM_VEC_L   = 10'(NUM_VEC);
  localparam logic [3:0]      SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  // Where a new vector goes once it has been applied: straight to capture when no settling.
  localparam state_t          VEC_ENTRY   = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_SETTLE;

  // Maximal-length 5-bit Fibonacci LFSR (x^5 + x^3 + 1), period 31, never reaches zero.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  // 10-bit MISR: shift with feedback from bits 9 and 6, then fold in the response.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m,
                                                 input logic [OUT_W-1:0] r);
    return {m[8:0], m[9] ^ m[6]} ^ r;
  endfunction

  state_t           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic [9:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
`ifdef STIM_RESP_CMP_EN
  logic             pass_q, pass_d;
`endif

  // Next-state and datapath: sequencing of settle/capture/report and LFSR/MISR updates.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    vec_d    = vec_q;
    settle_d = settle_q;
`ifdef STIM_RESP_CMP_EN
    pass_d   = pass_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_d   = SEED;
          misr_d   = '0;
          vec_d    = 10'd0;
          settle_d = 4'd0;
`ifdef STIM_RESP_CMP_EN
          pass_d   = 1'b0;
`endif
          state_d  = VEC_ENTRY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        misr_d = misr_step(misr_q, resp_data);
        lfsr_d = lfsr_step(lfsr_q);
        vec_d  = vec_q + 10'd1;
        if (vec_d == NUM_VEC_L) begin
          state_d = ST_REPORT;
`ifdef STIM_RESP_CMP_EN
          pass_d  = (misr_d == GOLDEN);
`endif
        end else begin
          state_d = VEC_ENTRY;
        end
      end
      ST_REPORT: begin
        if (valid_q && sig_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values derive from the next state so every output is a plain register.
  always_comb begin
    stim_d  = (state_d == ST_IDLE) ? '0 : lfsr_d;
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_REPORT);
  end

  // State and output registers; reset aborts any run with no report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      misr_q   <= '0;
      vec_q    <= 10'd0;
      settle_q <= 4'd0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef STIM_RESP_CMP_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef STIM_RESP_CMP_EN
      pass_q   <= pass_d;
`endif
    end
  end

  assign stim_data = stim_q;
  assign busy      = busy_q;
  assign sig_valid = valid_q;
  assign signature = misr_q;
  assign vec_count = vec_q;
`ifdef STIM_RESP_CMP_EN
  assign pass      = pass_q;
`endif

endmodule

// File: tb/tb_stim_response_engine.sv
// Scoreboard bench for stim_response_engine: expected reports are queued when a run is
// started, and a negedge monitor pops and compares whenever sig_valid rises.
module tb_stim_response_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic       start0, start1, start2;
  logic       ready0, ready1, ready2;
  logic [9:0] resp0, resp1, resp2;
  logic [4:0] stim0, stim1, stim2;
  logic       busy0, busy1, busy2;
  logic       sv0, sv1, sv2;
  logic [9:0] sig0, sig1, sig2;
  logic [9:0] vc0, vc1, vc2;
`ifdef STIM_RESP_CMP_EN
  logic       pass0, pass3, busy3, sv3;
  logic [4:0] stim3;
  logic [9:0] sig3, vc3;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [19:0] q0[$], q1[$], q2[$];
  logic [4:0]  seq [8];

  // dut0: NUM_VEC=2, no settle
  stim_response_engine #(
`ifdef STIM_RESP_CMP_EN
    .GOLDEN(10'h003),
`endif
    .NUM_VEC(2), .SETTLE_CYC(0), .LFSR_SEED(5'h01)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .resp_data(resp0), .stim_data(stim0),
    .busy(busy0), .sig_valid(sv0), .sig_ready(ready0), .signature(sig0), .vec_count(vc0)
`ifdef STIM_RESP_CMP_EN
    , .pass(pass0)
`endif
  );

  // dut1: NUM_VEC=4, one settle cycle
  stim_response_engine #(
`ifdef STIM_RESP_CMP_EN
    .GOLDEN(10'h000),
`endif
    .NUM_VEC(4), .SETTLE_CYC(1), .LFSR_SEED(5'h01)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .resp_data(resp1), .stim_data(stim1),
    .busy(busy1), .sig_valid(sv1), .sig_ready(ready1), .signature(sig1), .vec_count(vc1)
`ifdef STIM_RESP_CMP_EN
    , .pass()
`endif
  );

  // dut2: NUM_VEC=8, no settle, own reset for the mid-run abort
  stim_response_engine #(
`ifdef STIM_RESP_CMP_EN
    .GOLDEN(10'h000),
`endif
    .NUM_VEC(8), .SETTLE_CYC(0), .LFSR_SEED(5'h01)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .resp_data(resp2), .stim_data(stim2),
    .busy(busy2), .sig_valid(sv2), .sig_ready(ready2), .signature(sig2), .vec_count(vc2)
`ifdef STIM_RESP_CMP_EN
    , .pass()
`endif
  );

`ifdef STIM_RESP_CMP_EN
  // dut3: same run as dut0 but with a wrong golden value
  stim_response_engine #(
    .GOLDEN(10'h004), .NUM_VEC(2), .SETTLE_CYC(0), .LFSR_SEED(5'h01)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start0), .resp_data(resp0), .stim_data(stim3),
    .busy(busy3), .sig_valid(sv3), .sig_ready(ready0), .signature(sig3), .vec_count(vc3),
    .pass(pass3)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each rising sig_valid pop the expected {vec_count, signature} and compare.
  logic sv0_p = 1'b0, sv1_p = 1'b0, sv2_p = 1'b0;
  always @(negedge clk) begin
    logic [19:0] e;
    if (sv0 === 1'b1 && !sv0_p) begin
      check("dut0_report_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("dut0_signature", 32'(sig0), 32'(e[9:0]));
        check("dut0_vec_count", 32'(vc0), 32'(e[19:10]));
      end
    end
    if (sv1 === 1'b1 && !sv1_p) begin
      check("dut1_report_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut1_signature", 32'(sig1), 32'(e[9:0]));
        check("dut1_vec_count", 32'(vc1), 32'(e[19:10]));
      end
    end
    if (sv2 === 1'b1 && !sv2_p) begin
      check("dut2_report_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("dut2_signature", 32'(sig2), 32'(e[9:0]));
        check("dut2_vec_count", 32'(vc2), 32'(e[19:10]));
      end
    end
    sv0_p = (sv0 === 1'b1);
    sv1_p = (sv1 === 1'b1);
    sv2_p = (sv2 === 1'b1);
  end

  initial begin
    int cnt;
    seq[0] = 5'h01; seq[1] = 5'h02; seq[2] = 5'h04; seq[3] = 5'h09;
    seq[4] = 5'h12; seq[5] = 5'h05; seq[6] = 5'h0B; seq[7] = 5'h16;
    rst = 1'b1; rst2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
    resp0 = 10'h001; resp1 = 10'h000; resp2 = 10'h001;
    #12;
    check("reset_dut0", 32'({stim0, busy0, sv0, sig0, vc0}), 32'd0);
    check("reset_dut1", 32'({stim1, busy1, sv1, sig1, vc1}), 32'd0);
    check("reset_dut2", 32'({stim2, busy2, sv2, sig2, vc2}), 32'd0);
`ifdef STIM_RESP_CMP_EN
    check("reset_pass", 32'(pass0), 32'd0);
`endif
    rst = 1'b0; rst2 = 1'b0;
    tick();

    // dut0: 2 vectors of resp=1 -> signature 003, then held REPORT and handshake
    q0.push_back({10'd2, 10'h003});
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("dut0_stim_v0", 32'(stim0), 32'h01);
    check("dut0_busy_run", 32'(busy0), 32'd1);
    tick();
    check("dut0_stim_v1", 32'(stim0), 32'h02);
    check("dut0_vc_mid", 32'(vc0), 32'd1);
    tick();
    check("dut0_valid_latency", 32'(sv0), 32'd1);
    start0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dut0_hold_valid", 32'(sv0), 32'd1);
      check("dut0_hold_sig", 32'(sig0), 32'h003);
      check("dut0_hold_vc", 32'(vc0), 32'd2);
    end
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0; start0 = 1'b0;
    check("dut0_valid_drop", 32'(sv0), 32'd0);
    check("dut0_busy_idle", 32'(busy0), 32'd0);
    check("dut0_sig_held", 32'(sig0), 32'h003);
    check("dut0_stim_idle", 32'(stim0), 32'h00);
`ifdef STIM_RESP_CMP_EN
    check("pass_golden_match", 32'(pass0), 32'd1);
    check("pass_golden_miss", 32'(pass3), 32'd0);
`endif
    tick();
    check("dut0_start_not_queued", 32'(busy0), 32'd0);

    // dut1: 4 vectors, one settle cycle each -> valid after 8 cycles, signature 0
    q1.push_back({10'd4, 10'h000});
    start1 = 1'b1; tick(); start1 = 1'b0;
    cnt = 0;
    while (sv1 !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("dut1_latency", 32'(cnt), 32'd8);
    ready1 = 1'b1; tick(); ready1 = 1'b0;
    check("dut1_busy_idle", 32'(busy1), 32'd0);

    // dut2: LFSR sequence over 8 captures, with a dropped start mid-run
    q2.push_back({10'd8, 10'h0FE});
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("dut2_stim_v%0d", k), 32'(stim2), 32'(seq[k]));
      start2 = (k == 3);
      tick();
    end
    start2 = 1'b0;
    check("dut2_valid", 32'(sv2), 32'd1);
    ready2 = 1'b1; tick(); ready2 = 1'b0;

    // dut2: asynchronous reset at vec_count=3, then a clean full run
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick(); tick(); tick();
    check("dut2_vc_before_rst", 32'(vc2), 32'd3);
    #2 rst2 = 1'b1;
    #1;
    check("dut2_async_reset", 32'({stim2, busy2, sv2, sig2, vc2}), 32'd0);
    #1 rst2 = 1'b0;
    tick();
    check("dut2_idle_after_rst", 32'(busy2), 32'd0);
    q2.push_back({10'd8, 10'h0FE});
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("dut2_restart_seed", 32'(stim2), 32'h01);
    cnt = 0;
    while (sv2 !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("dut2_restart_latency", 32'(cnt), 32'd8);
    ready2 = 1'b1; tick(); ready2 = 1'b0;

    tick(); tick();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
